if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
// - Fetch sequencer for the IF stage of the 3-stage pipeline. Owns the PC and
//   the single instruction-memory port.
// - Each cycle it picks the next PC: sequential, jump, jump-register or branch.
// - It shares the imem port between instruction fetch and E-stage stores to
//   imem; a store wins and fetch stalls for that cycle.
// - It holds fetch off for a boot window after reset and produces the flush
//   and valid controls consumed by IF/E.
// PARAMETERS
// - RESET_PC     32'h0000_0000  PC loaded on reset
// - IMEM_AW      12             imem word-address width
// - BOOT_CYCLES  4              idle cycles after reset release before first fetch (>=1)
// - TRAP_PC      32'h0000_0100  redirect target on misaligned PC (IF_MISALIGN_TRAP_EN only)
// PORTS
// - Clk          in   1        system clock, all state on rising edge
// - Reset_n      in   1        asynchronous, active-low reset
// - Stall        in   1        hazard hold: freeze sequential PC advance
// - Branch_E     in   1        branch taken in E stage
// - Jump_E       in   1        jump in E stage
// - JReg         in   1        with Jump_E: target is JRegAddr, else Jaddr
// - Jaddr        in   32       jump target
// - JRegAddr     in   32       jump-register target
// - BranchAddr   in   32       branch target
// - WE_E         in   4        imem store byte enables; nonzero = store request
// - AddrToMem_E  in   IMEM_AW  imem store word address
// - WriteData_E  in   32       imem store data
// - ImemEn       out  1        imem port enable
// - ImemWE       out  4        imem byte write enables
// - ImemAddr     out  IMEM_AW  imem word address
// - ImemDin      out  32       imem write data
// - PC_F         out  32       PC of word being fetched
// - PCplus4_I    out  32       PC_F+4, registered alongside the fetch
// - FetchValid   out  1        imem data next cycle is a real instruction
// - Flush        out  1        kill instruction currently in IF/E register
// - FetchStall   out  1        combinational: fetch blocked this cycle
// - MisalignErr  out  1        sticky misaligned-target flag (macro only, else tied 0)
// BEHAVIOUR
// - Reset (Reset_n=0, async): PC_F=RESET_PC, PCplus4_I=RESET_PC+4, state=BOOT,
//   boot counter=0; ImemEn=0, ImemWE=0, FetchValid=0, Flush=0, MisalignErr=0.
//   Reset asserted mid-operation aborts everything immediately, including a
//   pending store, which is not performed.
// - FSM BOOT:
//   - Counts BOOT_CYCLES rising edges after Reset_n deasserts; ImemEn=0,
//     FetchStall=1.
//   - Redirects and stores are ignored.
//   - Moves to RUN when count==BOOT_CYCLES-1.
// - FSM RUN: ImemEn=1 every cycle.
//   - Store cycle (WE_E!=0): ImemWE=WE_E, ImemAddr=AddrToMem_E,
//     ImemDin=WriteData_E. FetchStall=1; PC holds unless redirected;
//     FetchValid<=0.
//   - Fetch cycle: ImemWE=0, ImemAddr=PC_F[IMEM_AW+1:2]; FetchValid<=1 unless
//     Stall or redirect.
//   - Next-PC priority: redirect > Stall > sequential.
//     - redirect = Jump_E|Branch_E.
//     - target = Jump_E ? (JReg ? JRegAddr : Jaddr) : BranchAddr.
//     - Jump_E beats Branch_E when both are set.
//   - Redirect: PC_F<=target, Flush=1 for exactly that cycle, FetchValid<=0.
//     Redirect also applies during Stall and during a store cycle.
//   - Stall without redirect: PC_F, PCplus4_I held; FetchValid<=0; same
//     address re-presented.
//   - Otherwise: PC_F<=PC_F+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
//     ImemAddr wraps naturally at 2^IMEM_AW words.
// - PCplus4_I always equals PC_F+4, both registered on the same edge.
// - Latency: instruction word is valid 1 cycle after its address is presented
//   (sync BRAM). Redirect-to-first-valid-target fetch is 2 cycles.
// CONFIGURATION
// - IF_MISALIGN_TRAP_EN defined:
//   - A redirect target with [1:0]!=0 sets MisalignErr, which is sticky until
//     reset.
//   - PC_F<=TRAP_PC instead of the target; Flush=1 as for any redirect.
// - IF_MISALIGN_TRAP_EN undefined:
//   - target[1:0] is silently forced to 2'b00.
//   - MisalignErr is tied 0.
// TESTING
// - Reset_n low 2 cycles, release, BOOT_CYCLES=4 -> ImemEn=0 for 4 cycles;
//   then PC_F=0,4,8,...; FetchValid=1 from cycle 6.
// - Running at PC_F=0x20, Stall=1 for 3 cycles -> PC_F stays 0x20,
//   FetchValid=0 x3; resumes at 0x24.
// - Branch_E=1, BranchAddr=0x80, same cycle Stall=1 -> Flush=1 one cycle;
//   next PC_F=0x80, then 0x84.
// - Jump_E=1, JReg=1, JRegAddr=0x40, Jaddr=0x90, Branch_E=1 -> PC_F=0x40.
// - WE_E=4'hF, AddrToMem_E=0x010, WriteData_E=0xDEADBEEF at PC_F=0x30 ->
//   ImemWE=F, ImemAddr=0x010, FetchStall=1; PC_F stays 0x30; readback at word
//   0x010 = 0xDEADBEEF.
// - Jaddr=0x42 with macro -> MisalignErr=1, PC_F=0x100. Without macro ->
//   PC_F=0x40, MisalignErr=0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer.
// Owns the PC and the single instruction-memory port. The port is shared
// between instruction fetch and E-stage stores into imem. A store takes the
// port, and fetch stalls for that cycle. Fetch is held off for a boot window
// after reset. The block also produces the Flush and FetchValid controls for IF/E.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target sets sticky MisalignErr and the
//               PC is sent to TRAP_PC instead.
//   undefined : target[1:0] is forced to 2'b00 and MisalignErr is tied 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_BOOT | post-reset idle window, imem disabled, redirects/stores ignored
// S_RUN  | imem enabled every cycle, fetching or servicing a store

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_AW     = 12,
  parameter int          BOOT_CYCLES = 4,
  parameter logic [31:0] TRAP_PC     = 32'h0000_0100
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Stall,
  input  logic               Branch_E,
  input  logic               Jump_E,
  input  logic               JReg,
  input  logic [31:0]        Jaddr,
  input  logic [31:0]        JRegAddr,
  input  logic [31:0]        BranchAddr,
  input  logic [3:0]         WE_E,
  input  logic [IMEM_AW-1:0] AddrToMem_E,
  input  logic [31:0]        WriteData_E,
  output logic               ImemEn,
  output logic [3:0]         ImemWE,
  output logic [IMEM_AW-1:0] ImemAddr,
  output logic [31:0]        ImemDin,
  output logic [31:0]        PC_F,
  output logic [31:0]        PCplus4_I,
  output logic               FetchValid,
  output logic               Flush,
  output logic               FetchStall,
  output logic               MisalignErr
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] boot_cnt_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_plus4_q;
  logic             fetch_valid_q;

  logic             run;
  logic             store_req;
  logic             redirect;
  logic [31:0]      target_raw;
  logic [31:0]      redir_pc;
  logic [31:0]      pc_d;
  logic             fetch_valid_d;

  // Next-PC selection: redirect beats Stall and store, which beat sequential.
  always_comb begin
    run        = (state_q == S_RUN);
    store_req  = |WE_E;
    redirect   = Jump_E | Branch_E;
    target_raw = Jump_E ? (JReg ? JRegAddr : Jaddr) : BranchAddr;
`ifdef IF_MISALIGN_TRAP_EN
    redir_pc   = (|target_raw[1:0]) ? TRAP_PC : target_raw;
`else
    redir_pc   = target_raw & ~32'h0000_0003;
`endif
    pc_d          = pc_q + 32'd4;
    fetch_valid_d = 1'b1;
    if (redirect) begin
      pc_d          = redir_pc;
      fetch_valid_d = 1'b0;
    end else if (Stall || store_req) begin
      pc_d          = pc_q;
      fetch_valid_d = 1'b0;
    end
  end

  // Imem port mux. A store owns the port; otherwise the current PC is presented.
  always_comb begin
    ImemEn     = run;
    ImemWE     = 4'h0;
    ImemAddr   = pc_q[IMEM_AW+1:2];
    ImemDin    = 32'h0000_0000;
    Flush      = run & redirect;
    FetchStall = ~run;
    if (run && store_req) begin
      ImemWE     = WE_E;
      ImemAddr   = AddrToMem_E;
      ImemDin    = WriteData_E;
      FetchStall = 1'b1;
    end
  end

  // Sequencer state: boot window, then PC/valid tracking while running.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_BOOT;
      boot_cnt_q    <= '0;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      fetch_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          fetch_valid_q <= 1'b0;
          if (boot_cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
            state_q <= S_RUN;
          end else begin
            boot_cnt_q <= boot_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          pc_q          <= pc_d;
          pc_plus4_q    <= pc_d + 32'd4;
          fetch_valid_q <= fetch_valid_d;
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;

  // Sticky flag for any misaligned redirect target taken while running.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      misalign_q <= 1'b0;
    end else if (run && redirect && (|target_raw[1:0])) begin
      misalign_q <= 1'b1;
    end
  end

  assign MisalignErr = misalign_q;
`else
  assign MisalignErr = 1'b0;
`endif

  assign PC_F       = pc_q;
  assign PCplus4_I  = pc_plus4_q;
  assign FetchValid = fetch_valid_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed bench for if_fetch_ctrl with a small sync imem model.
module tb_if_fetch_ctrl;

  localparam int IMEM_AW = 12;

  logic               clk_sys = 1'b0;
  logic               rst_n;
  logic               stall;
  logic               branch_e;
  logic               jump_e;
  logic               jreg;
  logic [31:0]        jaddr;
  logic [31:0]        jreg_addr;
  logic [31:0]        branch_addr;
  logic [3:0]         we_e;
  logic [IMEM_AW-1:0] addr_to_mem_e;
  logic [31:0]        write_data_e;
  logic               imem_en;
  logic [3:0]         imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_din;
  logic [31:0]        pc_f;
  logic [31:0]        pc_plus4;
  logic               fetch_valid;
  logic               flush;
  logic               fetch_stall;
  logic               misalign_err;

  logic [31:0] mem [0:(1<<IMEM_AW)-1];
  logic [31:0] imem_rdata;

  int n_chk = 0;
  int n_err = 0;

  if_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_AW     (IMEM_AW),
    .BOOT_CYCLES (4),
    .TRAP_PC     (32'h0000_0100)
  ) dut (
    .Clk         (clk_sys),
    .Reset_n     (rst_n),
    .Stall       (stall),
    .Branch_E    (branch_e),
    .Jump_E      (jump_e),
    .JReg        (jreg),
    .Jaddr       (jaddr),
    .JRegAddr    (jreg_addr),
    .BranchAddr  (branch_addr),
    .WE_E        (we_e),
    .AddrToMem_E (addr_to_mem_e),
    .WriteData_E (write_data_e),
    .ImemEn      (imem_en),
    .ImemWE      (imem_we),
    .ImemAddr    (imem_addr),
    .ImemDin     (imem_din),
    .PC_F        (pc_f),
    .PCplus4_I   (pc_plus4),
    .FetchValid  (fetch_valid),
    .Flush       (flush),
    .FetchStall  (fetch_stall),
    .MisalignErr (misalign_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous read-first imem with byte enables.
  always @(posedge clk_sys) begin
    if (imem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (imem_we[b]) mem[imem_addr][8*b +: 8] <= imem_din[8*b +: 8];
      end
      imem_rdata <= mem[imem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_in;
    stall = 0; branch_e = 0; jump_e = 0; jreg = 0;
    jaddr = 0; jreg_addr = 0; branch_addr = 0;
    we_e = 0; addr_to_mem_e = 0; write_data_e = 0;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_pc", pc_f, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_en", imem_en, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_mis", misalign_err, 0);

    // Boot window; redirect and store requests must be ignored.
    rst_n = 1'b1;
    jump_e = 1; jaddr = 32'h90; we_e = 4'hF; addr_to_mem_e = 12'h005; write_data_e = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("boot_en", imem_en, 0);
      chk("boot_fstall", fetch_stall, 1);
      chk("boot_we", imem_we, 0);
      chk("boot_flush", flush, 0);
      @(negedge clk_sys);
    end
    clr_in();
    #1;
    chk("run_en", imem_en, 1);
    chk("run_pc0", pc_f, 32'h0);
    chk("run_fv0", fetch_valid, 0);
    chk("run_addr0", imem_addr, 12'h000);
    @(negedge clk_sys);
    chk("seq_pc4", pc_f, 32'h4);
    chk("seq_fv", fetch_valid, 1);
    @(negedge clk_sys);
    chk("seq_pc8", pc_f, 32'h8);
    repeat (6) @(negedge clk_sys);
    chk("seq_pc20", pc_f, 32'h20);
    chk("seq_pc4_20", pc_plus4, 32'h24);

    // Hazard stall for three cycles at 0x20.
    stall = 1;
    #1;
    chk("stall_addr", imem_addr, 12'h008);
    chk("stall_fstall", fetch_stall, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      if (k == 2) stall = 0;
      chk("stall_pc", pc_f, 32'h20);
      chk("stall_fv", fetch_valid, 0);
    end
    @(negedge clk_sys);
    chk("resume_pc", pc_f, 32'h24);
    chk("resume_fv", fetch_valid, 1);

    // Branch taken together with Stall.
    branch_e = 1; branch_addr = 32'h80; stall = 1;
    #1;
    chk("br_flush", flush, 1);
    @(negedge clk_sys);
    clr_in();
    #1;
    chk("br_pc", pc_f, 32'h80);
    chk("br_pc4", pc_plus4, 32'h84);
    chk("br_flush_off", flush, 0);
    chk("br_fv", fetch_valid, 0);
    @(negedge clk_sys);
    chk("br_pc_next", pc_f, 32'h84);
    chk("br_fv_next", fetch_valid, 1);

    // Jump-register beats Jaddr and branch.
    jump_e = 1; jreg = 1; jreg_addr = 32'h40; jaddr = 32'h90; branch_e = 1; branch_addr = 32'h200;
    #1;
    chk("jr_flush", flush, 1);
    @(negedge clk_sys);
    clr_in();
    chk("jr_pc", pc_f, 32'h40);
    jump_e = 1; jaddr = 32'h30;
    @(negedge clk_sys);
    clr_in();
    chk("j_pc", pc_f, 32'h30);

    // Store into imem at PC 0x30.
    we_e = 4'hF; addr_to_mem_e = 12'h010; write_data_e = 32'hDEAD_BEEF;
    #1;
    chk("st_we", imem_we, 4'hF);
    chk("st_addr", imem_addr, 12'h010);
    chk("st_din", imem_din, 32'hDEAD_BEEF);
    chk("st_fstall", fetch_stall, 1);
    @(negedge clk_sys);
    clr_in();
    chk("st_pc_hold", pc_f, 32'h30);
    chk("st_fv", fetch_valid, 0);
    chk("st_mem", mem[16], 32'hDEAD_BEEF);
    @(negedge clk_sys);
    chk("st_pc_next", pc_f, 32'h34);
    chk("st_fv_next", fetch_valid, 1);

    // Fetch the stored word back.
    jump_e = 1; jaddr = 32'h40;
    @(negedge clk_sys);
    clr_in();
    #1;
    chk("rb_pc", pc_f, 32'h40);
    chk("rb_addr", imem_addr, 12'h010);
    @(negedge clk_sys);
    chk("rb_data", imem_rdata, 32'hDEAD_BEEF);
    chk("rb_fv", fetch_valid, 1);

    // Partial store combined with a branch redirect.
    we_e = 4'b0011; addr_to_mem_e = 12'h011; write_data_e = 32'h1234_5678;
    branch_e = 1; branch_addr = 32'h60;
    #1;
    chk("stbr_flush", flush, 1);
    @(negedge clk_sys);
    clr_in();
    chk("stbr_pc", pc_f, 32'h60);
    chk("stbr_mem", {16'h0, mem[17][15:0]}, 32'h0000_5678);

    // PC wrap at the top of the address space.
    jump_e = 1; jaddr = 32'hFFFF_FFFC;
    @(negedge clk_sys);
    clr_in();
    #1;
    chk("wrap_pc", pc_f, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 12'hFFF);
    @(negedge clk_sys);
    chk("wrap_pc0", pc_f, 32'h0);
    chk("wrap_pc4b", pc_plus4, 32'h4);

    // Misaligned jump target.
    jump_e = 1; jaddr = 32'h42;
    @(negedge clk_sys);
    clr_in();
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_pc", pc_f, 32'h100);
    chk("mis_flag", misalign_err, 1);
    @(negedge clk_sys);
    chk("mis_sticky", misalign_err, 1);
    chk("mis_pc_next", pc_f, 32'h104);
`else
    chk("mis_pc", pc_f, 32'h40);
    chk("mis_flag", misalign_err, 0);
    @(negedge clk_sys);
    chk("mis_flag2", misalign_err, 0);
    chk("mis_pc_next", pc_f, 32'h44);
`endif

    // Reset mid-cycle aborts a pending store.
    we_e = 4'hF; addr_to_mem_e = 12'h020; write_data_e = 32'hCAFE_F00D;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_en", imem_en, 0);
    chk("arst_we", imem_we, 0);
    chk("arst_pc", pc_f, 32'h0);
    chk("arst_fv", fetch_valid, 0);
    chk("arst_mis", misalign_err, 0);
    @(negedge clk_sys);
    chk("arst_nostore", (mem[32] === 32'hCAFE_F00D), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
